// File: rtl/fifo_pkg.sv
// Shared constants for the core-test-path FIFO: default geometry,
// almost-full/almost-empty thresholds and the error counter width.
package fifo_pkg;

    localparam int DEF_WID  = 8;
    localparam int DEF_AW   = 4;
    localparam int DEF_AFTH = 12;
    localparam int DEF_AETH = 4;
    localparam int ERRCNT_W = 16;

endpackage : fifo_pkg

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM, 2^AW x WID: synchronous write port and a registered
// read port. Only the read data register is reset, so the FIFO output comes
// up as zero while the storage array itself stays uninitialised.
module fifo_dpram #(
    parameter int WID = 8,
    parameter int AW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wren,
    input  logic [AW-1:0]  wraddr,
    input  logic [WID-1:0] wrdata,
    input  logic           rden,
    input  logic [AW-1:0]  rdaddr,
    output logic [WID-1:0] rddata
);

    logic [WID-1:0] mem [2**AW];

    // Storage array write; no reset so it maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wraddr] <= wrdata;
        end
    end

    // Read register loads only on a read and otherwise holds the last word;
    // a same-address write in the same cycle returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rddata <= '0;
        end else if (rden) begin
            rddata <= mem[rdaddr];
        end
    end

endmodule : fifo_dpram

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO between the sequence-data generator and the traffic
// checker. Tracks occupancy with wrap-bit pointers, registers all status
// flags, and keeps sticky overflow/underflow indications.
// Optional feature: define FIFO_ERRCNT_EN to build 16-bit saturating
// dropped-write / ignored-read counters; otherwise ovfcnt/udfcnt are tied 0.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int WID  = DEF_WID,
    parameter int AW   = DEF_AW,
    parameter int AFTH = DEF_AFTH,
    parameter int AETH = DEF_AETH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifowr,
    input  logic [WID-1:0]      fifodi,
    input  logic                fiford,
    output logic [WID-1:0]      fifodo,
    output logic                fifodovld,
    output logic                fifofull,
    output logic                fifoempty,
    output logic                fifoafull,
    output logic                fifoaempty,
    output logic [AW:0]         fifolen,
    output logic                fifoovf,
    output logic                fifoudf,
    input  logic                errclr,
    output logic [ERRCNT_W-1:0] ovfcnt,
    output logic [ERRCNT_W-1:0] udfcnt
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] AFTH_V  = (AW + 1)'(AFTH);
    localparam logic [AW:0] AETH_V  = (AW + 1)'(AETH);

    logic [AW:0] wrptr, rdptr;
    logic [AW:0] wrptr_nxt, rdptr_nxt, level_nxt;
    logic        rdacc, wracc;
    logic        ovf_evt, udf_evt;
    logic        full_nxt, empty_nxt;

    // Accept decisions use the registered flags; a read at full frees the
    // slot the simultaneous write lands in, so that write is still taken.
    always_comb begin
        rdacc     = fiford & ~fifoempty;
        wracc     = fifowr & (~fifofull | rdacc);
        ovf_evt   = fifowr & ~wracc;
        udf_evt   = fiford & ~rdacc;
        wrptr_nxt = wracc ? wrptr + PTR_ONE : wrptr;
        rdptr_nxt = rdacc ? rdptr + PTR_ONE : rdptr;
        level_nxt = wrptr_nxt - rdptr_nxt;
        full_nxt  = (wrptr_nxt[AW] != rdptr_nxt[AW]) &&
                    (wrptr_nxt[AW-1:0] == rdptr_nxt[AW-1:0]);
        empty_nxt = (wrptr_nxt == rdptr_nxt);
    end

    // Pointers and status flags, registered from the post-edge pointer values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr      <= '0;
            rdptr      <= '0;
            fifolen    <= '0;
            fifofull   <= 1'b0;
            fifoempty  <= 1'b1;
            fifoafull  <= 1'b0;
            fifoaempty <= 1'b1;
        end else begin
            wrptr      <= wrptr_nxt;
            rdptr      <= rdptr_nxt;
            fifolen    <= level_nxt;
            fifofull   <= full_nxt;
            fifoempty  <= empty_nxt;
            fifoafull  <= (level_nxt >= AFTH_V);
            fifoaempty <= (level_nxt <= AETH_V);
        end
    end

    // Output strobe tracks accepted reads one cycle later; the async reset
    // kills any read that was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifodovld <= 1'b0;
        end else begin
            fifodovld <= rdacc;
        end
    end

    // Sticky error flags: a new event in the errclr cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifoovf <= 1'b0;
            fifoudf <= 1'b0;
        end else begin
            fifoovf <= ovf_evt | (fifoovf & ~errclr);
            fifoudf <= udf_evt | (fifoudf & ~errclr);
        end
    end

`ifdef FIFO_ERRCNT_EN
    localparam logic [ERRCNT_W-1:0] CNT_ONE = ERRCNT_W'(1);

    // Saturating dropped-write counter; errclr with a coincident event leaves 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfcnt <= '0;
        end else if (errclr) begin
            ovfcnt <= ovf_evt ? CNT_ONE : '0;
        end else if (ovf_evt && (ovfcnt != '1)) begin
            ovfcnt <= ovfcnt + CNT_ONE;
        end
    end

    // Saturating ignored-read counter, same clear/event rules as above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            udfcnt <= '0;
        end else if (errclr) begin
            udfcnt <= udf_evt ? CNT_ONE : '0;
        end else if (udf_evt && (udfcnt != '1)) begin
            udfcnt <= udfcnt + CNT_ONE;
        end
    end
`else
    assign ovfcnt = '0;
    assign udfcnt = '0;
`endif

    fifo_dpram #(
        .WID (WID),
        .AW  (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wren   (wracc),
        .wraddr (wrptr[AW-1:0]),
        .wrdata (fifodi),
        .rden   (rdacc),
        .rdaddr (rdptr[AW-1:0]),
        .rddata (fifodo)
    );

endmodule : sync_fifo_core

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench for sync_fifo_core: stimulus keeps a reference queue of
// stored words and pushes each expected read word; a negedge monitor pops
// and compares whenever fifodovld is presented.
module tb_sync_fifo_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifowr = 1'b0;
    logic [7:0]  fifodi = '0;
    logic        fiford = 1'b0;
    logic        errclr = 1'b0;
    logic [7:0]  fifodo;
    logic        fifodovld;
    logic        fifofull, fifoempty, fifoafull, fifoaempty;
    logic [4:0]  fifolen;
    logic        fifoovf, fifoudf;
    logic [15:0] ovfcnt, udfcnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    int         m_ovfcnt = 0;
    int         m_udfcnt = 0;

    sync_fifo_core dut (
        .clk        (clk),
        .rst        (rst),
        .fifowr     (fifowr),
        .fifodi     (fifodi),
        .fiford     (fiford),
        .fifodo     (fifodo),
        .fifodovld  (fifodovld),
        .fifofull   (fifofull),
        .fifoempty  (fifoempty),
        .fifoafull  (fifoafull),
        .fifoaempty (fifoaempty),
        .fifolen    (fifolen),
        .fifoovf    (fifoovf),
        .fifoudf    (fifoudf),
        .errclr     (errclr),
        .ovfcnt     (ovfcnt),
        .udfcnt     (udfcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status outputs against the reference model, one cycle after the edge.
    task automatic checkOutput();
        int lvl;
        lvl = mq.size();
        chk("fifolen",    int'(fifolen),    lvl);
        chk("fifofull",   int'(fifofull),   int'(lvl == 16));
        chk("fifoempty",  int'(fifoempty),  int'(lvl == 0));
        chk("fifoafull",  int'(fifoafull),  int'(lvl >= 12));
        chk("fifoaempty", int'(fifoaempty), int'(lvl <= 4));
        chk("fifoovf",    int'(fifoovf),    int'(m_ovf));
        chk("fifoudf",    int'(fifoudf),    int'(m_udf));
`ifdef FIFO_ERRCNT_EN
        chk("ovfcnt",     int'(ovfcnt),     m_ovfcnt);
        chk("udfcnt",     int'(udfcnt),     m_udfcnt);
`else
        chk("ovfcnt",     int'(ovfcnt),     0);
        chk("udfcnt",     int'(udfcnt),     0);
`endif
    endtask

    // One clock of stimulus, driven 1 time unit after a rising edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] d,
                                 input logic rd, input logic clr,
                                 output logic wacc);
        logic       racc;
        logic [7:0] rword;
        logic       ovf_e, udf_e;
        fifowr = wr;
        fifodi = d;
        fiford = rd;
        errclr = clr;
        rword  = '0;
        racc   = rd && (mq.size() != 0);
        wacc   = wr && ((mq.size() != 16) || racc);
        ovf_e  = wr && !wacc;
        udf_e  = rd && !racc;
        if (racc) rword = mq.pop_front();
        if (wacc) mq.push_back(d);
        m_ovf = ovf_e | (m_ovf & !clr);
        m_udf = udf_e | (m_udf & !clr);
        if (clr) begin
            m_ovfcnt = ovf_e ? 1 : 0;
            m_udfcnt = udf_e ? 1 : 0;
        end else begin
            if (ovf_e && m_ovfcnt != 65535) m_ovfcnt++;
            if (udf_e && m_udfcnt != 65535) m_udfcnt++;
        end
        @(posedge clk);
        if (racc) exp_q.push_back(rword);
        #1;
        fifowr = 1'b0;
        fiford = 1'b0;
        errclr = 1'b0;
        checkOutput();
    endtask

    // Monitor: every presented word must match the oldest expectation, and
    // every expectation must be presented in its cycle.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fifodovld) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dovld", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("read_data", int'(fifodo), int'(e));
                    end
                end else if (exp_q.size() != 0) begin
                    chk("missing_dovld", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic       acc;
        logic [7:0] seq;
        logic       w, r;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_fifodo", int'(fifodo), 0);
        chk("reset_dovld", int'(fifodovld), 0);
        rst = 1'b0;
        checkOutput();

        $display("[TB] fill to full, then overflow");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, acc);
        chk("full_level", int'(fifolen), 16);
        applyStimulus(1'b1, 8'd16, 1'b0, 1'b0, acc);
        chk("ovf_after_drop", int'(fifoovf), 1);

        $display("[TB] write and read together at full");
        applyStimulus(1'b1, 8'd16, 1'b1, 1'b0, acc);
        chk("full_rw_accept", int'(acc), 1);
        chk("full_rw_level", int'(fifolen), 16);

        $display("[TB] drain, then underflow from empty");
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, acc);
        chk("udf_set", int'(fifoudf), 1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, acc);
        chk("udf_cleared", int'(fifoudf), 0);

        $display("[TB] error event coincident with errclr");
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, acc);
        chk("udf_event_wins", int'(fifoudf), 1);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, acc);

        $display("[TB] 40 words through, wrapping pointers");
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, acc);
        for (int i = 1; i < 40; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, acc);
        chk("wrap_empty", int'(fifoempty), 1);

        $display("[TB] 50/50 traffic with sequential data");
        seq = '0;
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            applyStimulus(w, seq, r, 1'b0, acc);
            if (acc) seq = seq + 8'd1;
        end
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, acc);

        $display("[TB] reset with 8 words stored and a read in flight");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, acc);
        chk("dovld_before_rst", int'(fifodovld), 1);
        rst = 1'b1;
        exp_q.delete();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ovfcnt = 0;
        m_udfcnt = 0;
        #1;
        chk("rst_dovld_async", int'(fifodovld), 0);
        chk("rst_fifolen", int'(fifolen), 0);
        chk("rst_empty", int'(fifoempty), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, acc);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_fifo_core
